// File: rtl/adder_tree_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_arbiter_if
//  Description : Request/response and adder-tree bus for adder_tree_arbiter.
//                The slave modport is the arbiter's view; the master modport
//                is the requester/tree side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_tree_arbiter_if #(
  parameter int W = 8
) ();
  logic [1:0]       req_valid;
  logic [8*W-1:0]   req_data0;
  logic [8*W-1:0]   req_data1;
  logic [1:0]       req_ready;
  logic             tree_valid;
  logic [8*W-1:0]   tree_data;
  logic [W-1:0]     tree_sum;
  logic [1:0]       resp_valid;
  logic [W-1:0]     resp_sum;

  modport slave (
    input  req_valid, req_data0, req_data1, tree_sum,
    output req_ready, tree_valid, tree_data, resp_valid, resp_sum
  );

  modport master (
    output req_valid, req_data0, req_data1, tree_sum,
    input  req_ready, tree_valid, tree_data, resp_valid, resp_sum
  );
endinterface
`default_nettype wire

// File: rtl/adder_tree_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_tree_arbiter
//  Description : Two-requester round-robin arbiter feeding an external
//                fixed-latency adder tree. A tag pipe tracks which requester
//                owns each operation and routes the tree result back.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_arbiter #(
  parameter int W   = 8,
  parameter int LAT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  adder_tree_arbiter_if.slave bus,
  output logic                drained,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
);

  // Wide enough to hold LAT tag entries plus the pending issue stage.
  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;            // id of last granted requester
  logic             tree_valid_q, tree_valid_d;
  logic [8*W-1:0]   tree_data_q, tree_data_d;
  logic             issue_id_q, issue_id_d;    // owner of the operation on tree_valid
  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [LAT-1:0]   tag_id_q, tag_id_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [W-1:0]     resp_sum_q, resp_sum_d;
  logic [15:0]      cnt0_q, cnt0_d;
  logic [15:0]      cnt1_q, cnt1_d;

  logic [CW-1:0]    inflight;
  logic             grant_ok;
  logic             winner;
  logic [1:0]       ready;
  logic             handshake;

  // Count operations issued to the tree whose response has not been captured.
  always_comb begin
    inflight = CW'(tree_valid_q);
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(tag_vld_q[i]);
    end
  end

  // Round-robin grant: a tie goes to the requester not granted last.
  always_comb begin
    grant_ok = (state_q == RUN) && en;
    winner   = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
    ready    = 2'b00;
    if (grant_ok && (bus.req_valid != 2'b00)) begin
      ready = winner ? 2'b10 : 2'b01;
    end
    handshake = |(ready & bus.req_valid);
  end

  // Next-state logic for the IDLE/RUN/DRAIN controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = (inflight != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (en)                   state_d = RUN;
        else if (inflight == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue stage, tag pipe, response capture and grant counters.
  always_comb begin
    last_d       = last_q;
    tree_valid_d = handshake;
    tree_data_d  = tree_data_q;
    issue_id_d   = issue_id_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (handshake) begin
      last_d      = winner;
      issue_id_d  = winner;
      tree_data_d = winner ? bus.req_data1 : bus.req_data0;
      if (winner) cnt1_d = cnt1_q + 16'd1;
      else        cnt0_d = cnt0_q + 16'd1;
    end

    // The issue stage feeds the tag pipe so the tag reaches the pipe output
    // in the same cycle the tree presents the matching sum.
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = tree_valid_q;
    tag_id_d[0]  = issue_id_q;
    for (int i = 1; i < LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    resp_valid_d = 2'b00;
    resp_sum_d   = resp_sum_q;
    if (tag_vld_q[LAT-1]) begin
      resp_valid_d = tag_id_q[LAT-1] ? 2'b10 : 2'b01;
      resp_sum_d   = bus.tree_sum;
    end
  end

  // State registers; reset discards all in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      tree_valid_q <= 1'b0;
      tree_data_q  <= '0;
      issue_id_q   <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= 2'b00;
      resp_sum_q   <= '0;
      cnt0_q       <= 16'd0;
      cnt1_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      tree_valid_q <= tree_valid_d;
      tree_data_q  <= tree_data_d;
      issue_id_q   <= issue_id_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.tree_valid = tree_valid_q;
  assign bus.tree_data  = tree_data_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign drained        = (state_q == IDLE) && (inflight == '0);
  assign grant_cnt0     = cnt0_q;
  assign grant_cnt1     = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_tree_arbiter
//  Description : Self-checking bench for adder_tree_arbiter with an adder-tree
//                model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_tree_arbiter;

  localparam int W   = 8;
  localparam int LAT = 3;

  typedef struct {
    logic [1:0]   onehot;
    logic [W-1:0] sum;
    int           cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        drained;
  logic [15:0] gc0, gc1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        sbq[$];

  logic [W-1:0] tm_sum [LAT];

  adder_tree_arbiter_if #(.W(W)) bus ();

  adder_tree_arbiter #(.W(W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .drained    (drained),
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] sum8(input logic [8*W-1:0] d);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + d[k*W +: W];
    return s;
  endfunction

  // Adder-tree model: LAT-cycle pipeline of operand sums.
  always @(posedge clk) begin
    tm_sum[0] <= sum8(bus.tree_data);
    for (int i = 1; i < LAT; i++) tm_sum[i] <= tm_sum[i-1];
  end
  assign bus.tree_sum = tm_sum[LAT-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every resp_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.resp_valid != 2'b00)) begin
      if (sbq.size() == 0) begin
        check_eq("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        check_eq("resp_id",  64'(bus.resp_valid), 64'(e.onehot));
        check_eq("resp_sum", 64'(bus.resp_sum),   64'(e.sum));
        check_eq("resp_lat", 64'(cyc),            64'(e.cyc));
      end
    end
  end

  // One cycle of stimulus: drive at posedge+1, check ready at negedge.
  task automatic drive_cycle(input logic en_i, input logic [1:0] v,
                             input logic [8*W-1:0] d0, input logic [8*W-1:0] d1,
                             input logic [1:0] exp_rdy, input string tag);
    exp_t e;
    en            = en_i;
    bus.req_valid = v;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    @(negedge clk);
    check_eq(tag, 64'(bus.req_ready), 64'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      e.onehot = exp_rdy;
      e.sum    = sum8(exp_rdy[1] ? d1 : d0);
      e.cyc    = cyc + LAT + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 30;
    while (sbq.size() != 0 && budget > 0) begin
      drive_cycle(1'b1, 2'b00, '0, '0, 2'b00, "idle_ready");
      budget--;
    end
    if (budget == 0) check_eq(tag, 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"},      64'(bus.req_ready),  64'd0);
    check_eq({tag, "_drained"},    64'(drained),        64'd1);
    check_eq({tag, "_tree_valid"}, 64'(bus.tree_valid), 64'd0);
    check_eq({tag, "_tree_data"},  64'(bus.tree_data),  64'd0);
    check_eq({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check_eq({tag, "_resp_sum"},   64'(bus.resp_sum),   64'd0);
    check_eq({tag, "_gc0"},        64'(gc0),            64'd0);
    check_eq({tag, "_gc1"},        64'(gc1),            64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_values("rst");
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [8*W-1:0] d_a, d_ff, r0, r1;
    int             guard;

    bus.req_valid = 2'b11;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;

    // IDLE never grants, even with en=1; this cycle moves to RUN.
    drive_cycle(1'b1, 2'b01, '0, '0, 2'b00, "idle_no_grant");

    // Single requester 0 with operands 1..8 (sum 0x24).
    for (int k = 0; k < 8; k++) d_a[k*W +: W] = W'(k + 1);
    drive_cycle(1'b1, 2'b01, d_a, '0, 2'b01, "t032_ready");
    check_eq("t032_tree_valid", 64'(bus.tree_valid), 64'd1);
    check_eq("t032_tree_data",  64'(bus.tree_data),  64'(d_a));
    wait_drain("t032_timeout");

    // Requester 1 with 8 x 0xFF (sum wraps to 0xF8).
    d_ff = '1;
    drive_cycle(1'b1, 2'b10, '0, d_ff, 2'b10, "t034_ready");
    wait_drain("t034_timeout");

    // Fresh reset: requester 0 wins the first tie, then strict alternation.
    do_reset();
    drive_cycle(1'b1, 2'b00, '0, '0, 2'b00, "idle_ready");
    for (int i = 0; i < 6; i++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      drive_cycle(1'b1, 2'b11, r0, r1, (i % 2 == 0) ? 2'b01 : 2'b10, "t033_rr");
    end
    wait_drain("t033_timeout");
    check_eq("t033_gc0", 64'(gc0), 64'd3);
    check_eq("t033_gc1", 64'(gc1), 64'd3);

    // Three back-to-back issues, then en drops while req_valid stays high.
    for (int i = 0; i < 3; i++) begin
      r0 = {$urandom, $urandom};
      drive_cycle(1'b1, 2'b01, r0, '0, 2'b01, "t035_b2b");
    end
    drive_cycle(1'b0, 2'b01, r0, '0, 2'b00, "t035_en_low");
    check_eq("t035_not_drained", 64'(drained), 64'd0);
    guard = 20;
    while (sbq.size() != 0 && guard > 0) begin
      drive_cycle(1'b0, 2'b01, r0, '0, 2'b00, "t035_drain_ready");
      guard--;
    end
    if (guard == 0) check_eq("t035_timeout", 64'(sbq.size()), 64'd0);
    check_eq("t035_drained", 64'(drained), 64'd1);

    // Reset with two operations in flight: nothing may come back.
    drive_cycle(1'b1, 2'b00, '0, '0, 2'b00, "idle_ready");
    drive_cycle(1'b1, 2'b01, {$urandom, $urandom}, '0, 2'b01, "t036_issue0");
    drive_cycle(1'b1, 2'b10, '0, {$urandom, $urandom}, 2'b10, "t036_issue1");
    bus.req_valid = 2'b11;
    do_reset();
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 2'b00, '0, '0, 2'b00, "t036_quiet");

    // Grant counter wrap for requester 0.
    for (int i = 0; i < 65535; i++) begin
      drive_cycle(1'b1, 2'b01, {$urandom, $urandom}, '0, 2'b01, "t037_ready");
    end
    check_eq("t037_ffff", 64'(gc0), 64'hFFFF);
    drive_cycle(1'b1, 2'b01, {$urandom, $urandom}, '0, 2'b01, "t037_ready");
    check_eq("t037_wrap0", 64'(gc0), 64'h0000);
    drive_cycle(1'b1, 2'b01, {$urandom, $urandom}, '0, 2'b01, "t037_ready");
    check_eq("t037_wrap1", 64'(gc0), 64'h0001);
    check_eq("t037_gc1",   64'(gc1), 64'h0000);
    wait_drain("t037_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/adder_tree_arbiter.md
ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 Parameter: W, 8, operand and sum width in bits.
REQ-002 Parameter: LAT, 3, adder-tree latency in cycles from tree_valid to tree_sum.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 en  input  1  1 = grants allowed; 0 = stop issuing and drain in-flight work.
REQ-006 req_valid  input  2  per-requester operation request.
REQ-007 req_data0  input  8*W  requester 0 operands; operand k in bits [k*W +: W].
REQ-008 req_data1  input  8*W  requester 1 operands; same packing.
REQ-009 req_ready  output  2  grant; handshake on req_valid[i] & req_ready[i] at a rising edge.
REQ-010 tree_valid  output  1  registered; issues one operand set to the adder tree.
REQ-011 tree_data  output  8*W  registered operand set driven to the tree.
REQ-012 tree_sum  input  W  tree result, valid exactly LAT cycles after the matching tree_valid cycle.
REQ-013 resp_valid  output  2  registered one-cycle, one-hot result strobe to the owning requester.
REQ-014 resp_sum  output  W  registered result, valid while any resp_valid bit is 1.
REQ-015 drained  output  1  1 when no operation is in flight and the FSM is in IDLE.
REQ-016 grant_cnt0, grant_cnt1  output  16 each  handshakes accepted per requester.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN when en=1; RUN->DRAIN when en=0 and in-flight>0; RUN->IDLE when en=0 and in-flight=0; DRAIN->IDLE when in-flight reaches 0; DRAIN->RUN when en=1.
REQ-019 req_ready SHALL be nonzero only in RUN with en=1, and SHALL be at most one-hot.
REQ-020 req_ready[i] SHALL depend combinationally on req_valid in the same cycle.
REQ-021 Arbitration SHALL be round-robin.
  - Single valid requester wins.
  - Both valid: the requester not granted last wins.
  - Pointer updates only on a handshake.
REQ-022 On a handshake, at that edge: tree_valid<=1, tree_data<=winner's data, a tag pipe of depth LAT captures {valid=1, id=winner}; otherwise tree_valid<=0 and tree_data holds.
REQ-023 When the tag-pipe output is valid, at the next edge: resp_sum<=tree_sum and resp_valid<=one-hot(id). Total latency SHALL be LAT+1 cycles from the tree_valid cycle to the resp_valid cycle.
REQ-024 Throughput SHALL be one issue per cycle. Back-to-back grants to the same requester SHALL be allowed when only it is valid.
REQ-025 in-flight = count of valid tag-pipe entries plus a pending tree_valid. It SHALL never exceed LAT+1.
REQ-026 Arithmetic is performed by the tree. This block SHALL pass tree_sum unmodified (mod 2^W wrap belongs to the tree).
REQ-027 grant_cntN SHALL increment by 1 per handshake and wrap 0xFFFF->0x0000.
REQ-028 If en falls in the same cycle as req_valid is high, that cycle SHALL NOT grant. Work already in flight SHALL still complete and respond.

Reset
REQ-029 rst_n=0 SHALL, asynchronously, set:
  - state=IDLE
  - tag pipe all invalid
  - tree_valid=0, tree_data=0
  - resp_valid=0, resp_sum=0
  - grant counters=0
  - round-robin pointer so requester 0 wins the first tie
REQ-030 While in reset, req_ready SHALL be 0 and drained SHALL be 1.
REQ-031 Reset mid-operation SHALL discard all in-flight tags; no resp_valid SHALL appear for pre-reset issues.

Verification
REQ-032 en=1, only req_valid[0]=1, operands 1..8 -> req_ready=01, tree_valid 1 cycle later, tree model returns 0x24, resp_valid=01 with resp_sum=0x24 at LAT+1 cycles after tree_valid.
REQ-033 Both requesters valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; grant_cnt0=3, grant_cnt1=3; resp_valid alternates 01/10 in the same order.
REQ-034 Requester 1 with 8 x 0xFF -> resp_valid=10, resp_sum=0xF8.
REQ-035 3 back-to-back issues, then en=0 -> state DRAIN, no further req_ready, 3 responses delivered, drained=1 one cycle after the last resp_valid.
REQ-036 rst_n pulled low with 2 operations in flight -> all outputs at reset values immediately; after release, no resp_valid until a new handshake.
REQ-037 grant_cnt0 preloaded near 0xFFFF by 2 grants -> wraps to 0x0000 then 0x0001.
